// File: rtl/serializador_pkg.sv
// Shared types and default parameters for the parallel-to-serial serializer.
`timescale 1ns/1ps
package serializador_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned CLK_DIV_DEF = 4;

endpackage

// File: rtl/generador_tick.sv
// Bit-rate divider: while running, pulses tick once every CLK_DIV cycles.
`timescale 1ns/1ps
module generador_tick
  import serializador_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == DivMax) ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the registered count; CLK_DIV=1 ticks on every running cycle.
  assign tick = run && (cnt_q == DivMax);

endmodule

// File: rtl/serializador_paralelo_serie.sv
// Parallel-to-serial converter: MSB-first bit stream with a per-bit strobe for a downstream
// shift stage and a one-cycle done pulse per word.
`timescale 1ns/1ps
module serializador_paralelo_serie
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic             accept, tick, last;

  assign accept = data_valid && data_ready;
  assign last   = tick && (bit_cnt_q == LastBit);

  generador_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .run  (state_q == SHIFT),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (data_valid) state_d = SHIFT;
      SHIFT: if (last)       state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready = 1'b0;
    busy       = 1'b0;
    shift_en   = 1'b0;
    unique case (state_q)
      IDLE:  data_ready = 1'b1;
      SHIFT: begin
        busy     = 1'b1;
        shift_en = tick;
      end
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = (state_q == SHIFT) && last;
    if (accept) begin
      shreg_d   = data_in;
      bit_cnt_d = '0;
    end else if ((state_q == SHIFT) && tick) begin
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  // A completed word leaves the register all-zero, so the MSB flop idles low.
  assign serial_out = shreg_q[WIDTH-1];
  assign done       = done_q;

endmodule

// File: tb/tb_serializador_paralelo_serie.sv
// Randomized self-checking bench: two serializers (CLK_DIV=4 and CLK_DIV=1) against a cycle-count model.
`timescale 1ns/1ps
module tb_serializador_paralelo_serie;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] din   [2];
  logic        valid [2];
  logic        ready [2];
  logic        sout  [2];
  logic        sen   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] dl    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  serializador_paralelo_serie #(
    .WIDTH  (32),
    .CLK_DIV(4)
  ) dut4 (
    .clock     (clock),
    .reset     (reset),
    .data_in   (din[0]),
    .data_valid(valid[0]),
    .data_ready(ready[0]),
    .serial_out(sout[0]),
    .shift_en  (sen[0]),
    .busy      (busy[0]),
    .done      (done[0])
  );

  serializador_paralelo_serie #(
    .WIDTH  (32),
    .CLK_DIV(1)
  ) dut1 (
    .clock     (clock),
    .reset     (reset),
    .data_in   (din[1]),
    .data_valid(valid[1]),
    .data_ready(ready[1]),
    .serial_out(sout[1]),
    .shift_en  (sen[1]),
    .busy      (busy[1]),
    .done      (done[1])
  );

  // Downstream 32-bit delay line clocked by the strobe.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (sen[i]) dl[i] <= {dl[i][30:0], sout[i]};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; offers w, follows the whole word through done.
  // With chain set, returns in the done cycle so the caller can offer the next word at once.
  task automatic serialize(input int i, input int div, input logic [31:0] w,
                           input bit noisy, input bit chain);
    din[i]   = w;
    valid[i] = 1'b1;
    check_eq("ready_at_offer", 32'(ready[i]), 32'd1);
    @(negedge clock);
    for (int c = 1; c <= 32 * div; c++) begin
      if (noisy) begin
        valid[i] = 1'($urandom);
        din[i]   = $urandom;
      end else begin
        valid[i] = 1'b0;
      end
      check_eq("busy_in_shift", 32'(busy[i]), 32'd1);
      check_eq("ready_in_shift", 32'(ready[i]), 32'd0);
      check_eq("done_in_shift", 32'(done[i]), 32'd0);
      check_eq("shift_en_timing", 32'(sen[i]), 32'((c % div) == 0));
      if ((c % div) == 0) begin
        int n;
        n = c / div - 1;
        check_eq("bit_value", 32'(sout[i]), 32'(w[31-n]));
      end
      @(negedge clock);
    end
    check_eq("done_pulse", 32'(done[i]), 32'd1);
    check_eq("ready_on_done", 32'(ready[i]), 32'd1);
    check_eq("busy_on_done", 32'(busy[i]), 32'd0);
    check_eq("shift_en_on_done", 32'(sen[i]), 32'd0);
    check_eq("serial_on_done", 32'(sout[i]), 32'd0);
    check_eq("delay_line", dl[i], w);
    if (!chain) begin
      valid[i] = 1'b0;
      @(negedge clock);
      check_eq("done_one_cycle", 32'(done[i]), 32'd0);
      check_eq("idle_after_done", 32'(busy[i]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      din[i]   = '0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_ready", 32'(ready[i]), 32'd1);
      check_eq("rst_busy", 32'(busy[i]), 32'd0);
      check_eq("rst_shift_en", 32'(sen[i]), 32'd0);
      check_eq("rst_done", 32'(done[i]), 32'd0);
      check_eq("rst_serial", 32'(sout[i]), 32'd0);
    end

    // Reset and data_valid on the same edge: word dropped.
    valid[0] = 1'b1;
    din[0]   = 32'hFFFF_FFFF;
    @(negedge clock);
    reset    = 1'b0;
    valid[0] = 1'b0;
    check_eq("rst_wins_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_wins_ready", 32'(ready[0]), 32'd1);
    @(negedge clock);
    check_eq("rst_wins_still_idle", 32'(busy[0]), 32'd0);

    serialize(1, 1, 32'h8000_0001, 1'b0, 1'b0);
    serialize(0, 4, 32'hA5A5_A5A5, 1'b0, 1'b0);
    serialize(0, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    serialize(0, 4, 32'h1234_5678, 1'b0, 1'b1);
    serialize(0, 4, 32'h9ABC_DEF0, 1'b0, 1'b0);
    serialize(0, 4, 32'hFFFF_FFFF, 1'b1, 1'b0);
    serialize(1, 1, 32'h1234_5678, 1'b0, 1'b1);
    serialize(1, 1, 32'h9ABC_DEF0, 1'b1, 1'b0);
    repeat (3) serialize(0, 4, $urandom, 1'($urandom), 1'($urandom));
    serialize(0, 4, $urandom, 1'b0, 1'b0);
    repeat (3) serialize(1, 1, $urandom, 1'($urandom), 1'($urandom));
    serialize(1, 1, $urandom, 1'b1, 1'b0);

    // Abort mid-word: reset for one cycle after the 10th strobe.
    din[0]   = $urandom;
    valid[0] = 1'b1;
    @(negedge clock);
    valid[0] = 1'b0;
    repeat (10 * 4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 160; c++) begin
      check_eq("abort_shift_en", 32'(sen[0]), 32'd0);
      check_eq("abort_done", 32'(done[0]), 32'd0);
      check_eq("abort_ready", 32'(ready[0]), 32'd1);
      check_eq("abort_serial", 32'(sout[0]), 32'd0);
      @(negedge clock);
    end

    serialize(0, 4, 32'hC3C3_3C3C, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
